// File: rtl/slsu_storebuf.sv
// Load/store unit with a posted-store FIFO in front of sdatamem.
// Define SLSU_MISALIGN_TRAP_EN to fault misaligned halfword/word accesses.
module slsu_storebuf #(
  parameter int DATA_WIDTH = 32,
  parameter int SB_DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic                         req_we_i,
  input  logic [1:0]                   req_size_i,
  input  logic                         req_unsigned_i,
  input  logic [DATA_WIDTH-1:0]        req_addr_i,
  input  logic [DATA_WIDTH-1:0]        req_wdata_i,
  output logic                         rsp_valid_o,
  output logic [DATA_WIDTH-1:0]        rsp_rdata_o,
  output logic                         rsp_fault_o,
  output logic                         mem_read_o,
  output logic                         mem_write_o,
  output logic [1:0]                   mem_size_o,
  output logic [DATA_WIDTH-1:0]        mem_addr_o,
  output logic [DATA_WIDTH-1:0]        mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]        mem_rdata_i,
  output logic                         sb_empty_o,
  output logic [$clog2(SB_DEPTH):0]    sb_count_o
);

  localparam int DW = DATA_WIDTH;
  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = PW + 1;

  logic [DW-1:0] sb_addr  [SB_DEPTH];
  logic [DW-1:0] sb_wdata [SB_DEPTH];
  logic [1:0]    sb_size  [SB_DEPTH];

  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;

  logic          misal;
  logic          hazard;
  logic          load_acc;
  logic          store_acc;
  logic          drain;
  logic [DW-1:0] ext;

  function automatic logic [DW-3:0] wlast(
    input logic [DW-1:0] a,
    input logic [1:0]    s
  );
    logic [DW-1:0] l;
    l = a + (s[1] ? DW'(3) : DW'(s[0]));
    return l[DW-1:2];
  endfunction

  // A request spans at most two words, so endpoint equality is sufficient.
  function automatic logic word_hit(
    input logic [DW-1:0] ea,
    input logic [1:0]    es,
    input logic [DW-1:0] ra,
    input logic [1:0]    rs
  );
    logic [DW-3:0] ef, el, rf, rl;
    ef = ea[DW-1:2];
    el = wlast(ea, es);
    rf = ra[DW-1:2];
    rl = wlast(ra, rs);
    return (ef == rf) || (ef == rl) ||
           (el == rf) || (el == rl);
  endfunction

`ifdef SLSU_MISALIGN_TRAP_EN
  assign misal = (req_size_i == 2'b01 && req_addr_i[0]) ||
                 (req_size_i[1] && req_addr_i[1:0] != 2'b00);
`else
  assign misal = 1'b0;
`endif

  always_comb begin
    logic [PW-1:0] off;
    hazard = 1'b0;
    off    = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      off = PW'(i) - head;
      if ({1'b0, off} < count &&
          word_hit(sb_addr[i], sb_size[i],
                   req_addr_i, req_size_i))
        hazard = 1'b1;
    end
  end

  always_comb begin
    req_ready_o = 1'b0;
    unique case (1'b1)
      misal:
        req_ready_o = 1'b1;
      (!misal && req_we_i):
        req_ready_o = count < CW'(SB_DEPTH);
      default:
        req_ready_o = !hazard;
    endcase
  end

  assign load_acc  = req_valid_i && req_ready_o &&
                     !req_we_i && !misal;
  assign store_acc = req_valid_i && req_ready_o &&
                     req_we_i && !misal;
  assign drain     = !load_acc && (count != '0);

  always_comb begin
    mem_read_o  = 1'b0;
    mem_write_o = 1'b0;
    mem_size_o  = 2'b00;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    unique case (1'b1)
      load_acc: begin
        mem_read_o = 1'b1;
        mem_size_o = req_size_i;
        mem_addr_o = req_addr_i;
      end
      drain: begin
        mem_write_o = 1'b1;
        mem_size_o  = sb_size[head];
        mem_addr_o  = sb_addr[head];
        mem_wdata_o = sb_wdata[head];
      end
      default: ;
    endcase
  end

  always_comb begin
    ext = mem_rdata_i;
    unique case (1'b1)
      (req_unsigned_i && req_size_i == 2'b00):
        ext = {{(DW-8){1'b0}}, mem_rdata_i[7:0]};
      (req_unsigned_i && req_size_i == 2'b01):
        ext = {{(DW-16){1'b0}}, mem_rdata_i[15:0]};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (store_acc) begin
      sb_addr[tail]  <= req_addr_i;
      sb_size[tail]  <= req_size_i;
      sb_wdata[tail] <= req_wdata_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_fault_o <= 1'b0;
    end else begin
      if (store_acc)
        tail <= tail + PW'(1);
      if (drain)
        head <= head + PW'(1);
      count       <= count + CW'(store_acc) - CW'(drain);
      rsp_valid_o <= req_valid_i && req_ready_o;
      rsp_rdata_o <= load_acc ? ext : '0;
      rsp_fault_o <= req_valid_i && misal;
    end
  end

  assign sb_empty_o = (count == '0);
  assign sb_count_o = count;

endmodule

// File: tb/tb_slsu_storebuf.sv
// Randomized bench for slsu_storebuf against a queue/byte-memory model.
// Includes a byte-addressed sdatamem stand-in driven by the DUT port.
module tb_slsu_storebuf;

  localparam int D = 4;
`ifdef SLSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [1:0]  req_size_i = 2'b00;
  logic        req_unsigned_i = 1'b0;
  logic [31:0] req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_fault_o;
  logic        mem_read_o, mem_write_o;
  logic [1:0]  mem_size_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic        sb_empty_o;
  logic [2:0]  sb_count_o;

  always #5 clk = ~clk;

  slsu_storebuf #(.DATA_WIDTH(32), .SB_DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_we_i(req_we_i), .req_size_i(req_size_i),
    .req_unsigned_i(req_unsigned_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
    .rsp_fault_o(rsp_fault_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .mem_size_o(mem_size_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .sb_empty_o(sb_empty_o), .sb_count_o(sb_count_o)
  );

  function automatic int nbytes(input logic [1:0] s);
    return s[1] ? 4 : (s[0] ? 2 : 1);
  endfunction

  function automatic logic [1:0] nsz(input logic [1:0] s);
    return s[1] ? 2'b10 : s;
  endfunction

  function automatic logic [7:0] init_byte(input int i);
    if (i == 256) return 8'h0D;
    if (i == 257) return 8'hF0;
    return 8'((i * 73 + 29) ^ (i >> 3));
  endfunction

  // sdatamem stand-in: byte array, sign-extending combinational read
  logic [7:0]  dmem [1024];
  logic        seed = 1'b1;
  logic [31:0] rd_w;

  always @(posedge clk) begin
    if (seed) begin
      for (int i = 0; i < 1024; i++) dmem[i] <= init_byte(i);
    end else if (mem_write_o) begin
      for (int k = 0; k < nbytes(mem_size_o); k++)
        dmem[10'(mem_addr_o + 32'(k))] <= mem_wdata_o[8*k +: 8];
    end
  end

  always_comb begin
    rd_w = {dmem[10'(mem_addr_o + 32'd3)], dmem[10'(mem_addr_o + 32'd2)],
            dmem[10'(mem_addr_o + 32'd1)], dmem[10'(mem_addr_o)]};
    mem_rdata_i = rd_w;
    case (mem_size_o)
      2'b00:   mem_rdata_i = {{24{rd_w[7]}}, rd_w[7:0]};
      2'b01:   mem_rdata_i = {{16{rd_w[15]}}, rd_w[15:0]};
      default: mem_rdata_i = rd_w;
    endcase
  end

  // Reference model
  typedef struct packed {
    logic [31:0] a;
    logic [1:0]  s;
    logic [31:0] d;
  } st_t;

  st_t         q[$];
  logic [7:0]  gmem [1024];
  logic        exp_rv, exp_flt;
  logic [31:0] exp_rd;
  int          n_tests = 0;
  int          n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ld_val(input logic [31:0] a,
                                         input logic [1:0] s, input bit un);
    logic [31:0] w;
    w = {gmem[10'(a + 32'd3)], gmem[10'(a + 32'd2)],
         gmem[10'(a + 32'd1)], gmem[10'(a)]};
    if (s == 2'b00) return un ? {24'b0, w[7:0]} : {{24{w[7]}}, w[7:0]};
    if (s == 2'b01) return un ? {16'b0, w[15:0]} : {{16{w[15]}}, w[15:0]};
    return w;
  endfunction

  function automatic bit overlap(input logic [31:0] ea, input logic [1:0] es,
                                 input logic [31:0] ra, input logic [1:0] rs);
    logic [31:0] ef, el, rf, rl;
    ef = ea >> 2;
    el = (ea + 32'(nbytes(es)) - 1) >> 2;
    rf = ra >> 2;
    rl = (ra + 32'(nbytes(rs)) - 1) >> 2;
    return !(el < rf || rl < ef);
  endfunction

  task automatic cycle(input bit v, input bit we, input logic [1:0] sz,
                       input bit un, input logic [31:0] a,
                       input logic [31:0] wd, output bit acc);
    bit          mis, haz, rdy, ld, st, dr;
    logic [31:0] ea, ew;
    logic [1:0]  es;
    req_valid_i    = v;
    req_we_i       = we;
    req_size_i     = sz;
    req_unsigned_i = un;
    req_addr_i     = a;
    req_wdata_i    = wd;
    @(negedge clk);
    check("rsp_valid", 32'(rsp_valid_o), 32'(exp_rv));
    check("rsp_rdata", rsp_rdata_o, exp_rd);
    check("rsp_fault", 32'(rsp_fault_o), 32'(exp_flt));
    check("sb_count", 32'(sb_count_o), 32'(q.size()));
    check("sb_empty", 32'(sb_empty_o), 32'(q.size() == 0));
    mis = TRAP && ((sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00));
    haz = 1'b0;
    foreach (q[i]) if (overlap(q[i].a, q[i].s, a, sz)) haz = 1'b1;
    rdy = mis ? 1'b1 : (we ? (q.size() < D) : !haz);
    check("req_ready", 32'(req_ready_o), 32'(rdy));
    acc = v && rdy;
    ld  = acc && !we && !mis;
    st  = acc && we && !mis;
    dr  = !ld && q.size() > 0;
    ea = '0; es = 2'b00; ew = '0;
    if (ld) begin
      ea = a; es = sz;
    end else if (dr) begin
      ea = q[0].a; es = q[0].s; ew = q[0].d;
    end
    check("mem_read", 32'(mem_read_o), 32'(ld));
    check("mem_write", 32'(mem_write_o), 32'(dr));
    check("mem_addr", mem_addr_o, ea);
    check("mem_size", 32'(nsz(mem_size_o)), 32'(nsz(es)));
    check("mem_wdata", mem_wdata_o, ew);
    exp_rv  = acc;
    exp_rd  = ld ? ld_val(a, sz, un) : 32'h0;
    exp_flt = acc && mis;
    if (dr) begin
      for (int k = 0; k < nbytes(q[0].s); k++)
        gmem[10'(q[0].a + 32'(k))] = q[0].d[8*k +: 8];
      void'(q.pop_front());
    end
    if (st) q.push_back('{a: a, s: sz, d: wd});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid_i = 1'b0;
    req_we_i    = 1'b0;
    req_size_i  = 2'b00;
    rst = 1'b1;
    #2;
    check("rst_count", 32'(sb_count_o), 32'd0);
    check("rst_empty", 32'(sb_empty_o), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("rst_rsp_rdata", rsp_rdata_o, 32'd0);
    check("rst_rsp_fault", 32'(rsp_fault_o), 32'd0);
    check("rst_mem_write", 32'(mem_write_o), 32'd0);
    check("rst_ready", 32'(req_ready_o), 32'd1);
    @(posedge clk);
    #1;
    seed = 1'b0;
    rst  = 1'b0;
    q.delete();
    exp_rv  = 1'b0;
    exp_rd  = '0;
    exp_flt = 1'b0;
  endtask

  initial begin
    bit acc;
    for (int i = 0; i < 1024; i++) gmem[i] = init_byte(i);
    do_reset();

    // store then drain
    cycle(1, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, acc);
    check("t1_rsp", 32'(rsp_valid_o), 32'd1);
    check("t1_count", 32'(sb_count_o), 32'd1);
    cycle(0, 0, 2'b00, 0, 32'h0, 32'h0, acc);
    check("t1_drained", 32'(sb_count_o), 32'd0);
    check("t1_mem", {dmem[19], dmem[18], dmem[17], dmem[16]}, 32'hDEADBEEF);

    // hazard: byte store then overlapping word load
    cycle(1, 1, 2'b00, 0, 32'h21, 32'h80, acc);
    cycle(1, 0, 2'b10, 0, 32'h20, 32'h0, acc);
    check("hz_count", 32'(sb_count_o), 32'd0);
    cycle(1, 0, 2'b10, 0, 32'h20, 32'h0, acc);
    cycle(1, 0, 2'b00, 0, 32'h21, 32'h0, acc);
    check("lb", rsp_rdata_o, 32'hFFFFFF80);
    cycle(1, 0, 2'b00, 1, 32'h21, 32'h0, acc);
    check("lbu", rsp_rdata_o, 32'h00000080);

    // load wins the port, drain waits
    cycle(1, 1, 2'b10, 0, 32'h40, 32'h12345678, acc);
    cycle(1, 0, 2'b01, 1, 32'h100, 32'h0, acc);
    check("lhu", rsp_rdata_o, 32'h0000F00D);
    check("lhu_defer", 32'(sb_count_o), 32'd1);
    cycle(0, 0, 2'b00, 0, 32'h0, 32'h0, acc);

    // misaligned word load
    cycle(1, 0, 2'b10, 0, 32'h03, 32'h0, acc);
    check("mis_fault", 32'(rsp_fault_o), 32'(TRAP));

    // reset with a store pending
    cycle(1, 1, 2'b10, 0, 32'h30, 32'hCAFEF00D, acc);
    do_reset();
    cycle(0, 0, 2'b00, 0, 32'h0, 32'h0, acc);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a;
      if ($urandom_range(0, 299) == 0) do_reset();
      a = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(250, 263))
                                      : 32'($urandom_range(0, 63));
      cycle($urandom_range(0, 9) < 8, 1'($urandom), 2'($urandom),
            1'($urandom), a, $urandom, acc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
